// File: rtl/syn_chk_ctrl.sv
// Serial syndrome checker and iteration controller: captures the hard-decision vector after each
// VFU pass, walks every H-row from an external ROM, and decides between another iteration and done.
module syn_chk_ctrl #(
    parameter int N_VN     = 533,
    parameter int N_CN     = 267,
    parameter int ROW_DEG  = 8,
    parameter int IDX_W    = 10,
    parameter int ADDR_W   = 9,
    parameter int CNT_W    = 9,
    parameter int MAX_ITER = 20,
    parameter int IT_W     = 5
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      flag_dec_start,
    input  logic                      flag_VFU_end,
    input  logic [N_VN-1:0]           bit_data_reg,
    output logic                      rom_re,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [ROW_DEG*IDX_W-1:0]  rom_data,
    output logic                      chk_busy,
    output logic                      flag_chk_end,
    output logic [CNT_W-1:0]          unsat_cnt,
    output logic [IT_W-1:0]           iter_cnt,
    output logic                      flag_iter_next,
    output logic                      flag_dec_done,
    output logic                      dec_success,
    output logic [N_VN-1:0]           dec_bits
);

    typedef enum logic [1:0] {IDLE, CAPT, RUN, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_CN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IT_W-1:0]   ITER_MAX = IT_W'(MAX_ITER);

    state_t              state_reg, state_next;
    logic [N_VN-1:0]     hd_reg;
    logic [ADDR_W-1:0]   row_reg;
    logic [CNT_W-1:0]    acc_reg;
    logic                rom_re_d_reg;
    logic [CNT_W-1:0]    unsat_reg;
    logic [IT_W-1:0]     iter_reg;
    logic                chk_end_reg, iter_next_reg, dec_done_reg, success_reg;
    logic [N_VN-1:0]     dec_bits_reg;

    logic [ROW_DEG-1:0]  slot_bit;
    logic                parity;
    logic [CNT_W-1:0]    acc_sum;
    logic [IT_W-1:0]     iter_new;

    // Each slot selects one hard decision; padding indices (>= N_VN) contribute nothing.
    generate
        for (genvar gi = 0; gi < ROW_DEG; gi++) begin : g_slot
            logic [IDX_W-1:0] idx;
            assign idx          = rom_data[gi*IDX_W +: IDX_W];
            assign slot_bit[gi] = (32'(idx) < N_VN) ? hd_reg[idx] : 1'b0;
        end
    endgenerate

    assign parity   = ^slot_bit;
    assign acc_sum  = (rom_re_d_reg && parity && acc_reg != CNT_MAX) ? acc_reg + 1'b1 : acc_reg;
    assign iter_new = (iter_reg == ITER_MAX) ? iter_reg : iter_reg + 1'b1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flag_dec_start) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (flag_VFU_end) state_next = CAPT;
                CAPT:    state_next = RUN;
                RUN:     if (row_reg == LAST_ROW) state_next = DRAIN;
                DRAIN:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hd_reg        <= '0;
            row_reg       <= '0;
            acc_reg       <= '0;
            rom_re_d_reg  <= 1'b0;
            unsat_reg     <= '0;
            iter_reg      <= '0;
            chk_end_reg   <= 1'b0;
            iter_next_reg <= 1'b0;
            dec_done_reg  <= 1'b0;
            success_reg   <= 1'b0;
            dec_bits_reg  <= '0;
        end else begin
            chk_end_reg   <= 1'b0;
            iter_next_reg <= 1'b0;
            dec_done_reg  <= 1'b0;
            rom_re_d_reg  <= (state_reg == RUN);
            if (flag_dec_start) begin
                // Abort: drop any in-flight result; dec_bits/dec_success keep the last decode.
                iter_reg     <= '0;
                acc_reg      <= '0;
                rom_re_d_reg <= 1'b0;
            end else begin
                case (state_reg)
                    CAPT: begin
                        hd_reg  <= bit_data_reg;
                        row_reg <= '0;
                        acc_reg <= '0;
                    end
                    RUN: begin
                        acc_reg <= acc_sum;
                        if (row_reg != LAST_ROW) row_reg <= row_reg + 1'b1;
                    end
                    DRAIN: begin
                        acc_reg     <= acc_sum;
                        unsat_reg   <= acc_sum;
                        iter_reg    <= iter_new;
                        chk_end_reg <= 1'b1;
                        if (acc_sum == '0) begin
                            dec_done_reg <= 1'b1;
                            success_reg  <= 1'b1;
                            dec_bits_reg <= hd_reg;
                        end else if (iter_new == ITER_MAX) begin
                            dec_done_reg <= 1'b1;
                            success_reg  <= 1'b0;
                            dec_bits_reg <= hd_reg;
                        end else begin
                            iter_next_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_re         = (state_reg == RUN);
    assign rom_addr       = row_reg;
    assign chk_busy       = (state_reg != IDLE);
    assign flag_chk_end   = chk_end_reg;
    assign unsat_cnt      = unsat_reg;
    assign iter_cnt       = iter_reg;
    assign flag_iter_next = iter_next_reg;
    assign flag_dec_done  = dec_done_reg;
    assign dec_success    = success_reg;
    assign dec_bits       = dec_bits_reg;

endmodule

// File: tb/tb_syn_chk_ctrl.sv
// Directed bench for syn_chk_ctrl with a behavioural registered-read H-row ROM.
module tb_syn_chk_ctrl;
    localparam int N_VN = 533, N_CN = 267, ROW_DEG = 8, IDX_W = 10;
    localparam int ADDR_W = 9, CNT_W = 9, MAX_ITER = 20, IT_W = 5;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst = 1'b1;
    logic                     flag_dec_start = 1'b0;
    logic                     flag_VFU_end = 1'b0;
    logic [N_VN-1:0]          bit_data_reg = '0;
    logic                     rom_re;
    logic [ADDR_W-1:0]        rom_addr;
    logic [ROW_DEG*IDX_W-1:0] rom_data = '0;
    logic                     chk_busy, flag_chk_end, flag_iter_next, flag_dec_done, dec_success;
    logic [CNT_W-1:0]         unsat_cnt;
    logic [IT_W-1:0]          iter_cnt;
    logic [N_VN-1:0]          dec_bits;

    logic [ROW_DEG*IDX_W-1:0] rom_mem [N_CN];
    int checks = 0, failures = 0;
    int cycle = 0;

    syn_chk_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .flag_dec_start(flag_dec_start),
        .flag_VFU_end(flag_VFU_end), .bit_data_reg(bit_data_reg), .rom_re(rom_re),
        .rom_addr(rom_addr), .rom_data(rom_data), .chk_busy(chk_busy),
        .flag_chk_end(flag_chk_end), .unsat_cnt(unsat_cnt), .iter_cnt(iter_cnt),
        .flag_iter_next(flag_iter_next), .flag_dec_done(flag_dec_done),
        .dec_success(dec_success), .dec_bits(dec_bits)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cycle <= cycle + 1;
    always @(posedge sys_clk) if (rom_re) rom_data <= rom_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [N_VN-1:0] obs, input logic [N_VN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge sys_clk) #1 flag_dec_start = 1'b1;
        @(posedge sys_clk) #1 flag_dec_start = 1'b0;
    endtask

    // One VFU pulse, then wait for flag_chk_end; lat is counted from the VFU cycle.
    task automatic run_pass(input string name, output int lat, output logic itn, output logic dd);
        int c0;
        logic got;
        got = 1'b0; lat = -1; itn = 1'b0; dd = 1'b0;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b1;
        c0 = cycle;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge sys_clk);
            if (flag_chk_end) begin
                got = 1'b1; lat = cycle - c0; itn = flag_iter_next; dd = flag_dec_done;
            end
        end
        check_eq({name, "_chk_end_seen"}, got, 1'b1);
        @(negedge sys_clk);
        check_eq({name, "_pulse_1cyc"}, {flag_chk_end, flag_iter_next, flag_dec_done}, 3'b000);
        $display("pass %s: lat=%0d unsat=%0d iter=%0d next=%0b done=%0b ok=%0b",
                 name, lat, unsat_cnt, iter_cnt, itn, dd, dec_success);
    endtask

    task automatic wait_row(input string name, input int row);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge sys_clk);
            if (rom_re && rom_addr == ADDR_W'(row)) found = 1'b1;
        end
        check_eq({name, "_row_reached"}, found, 1'b1);
    endtask

    initial begin
        int lat;
        logic itn, dd;
        int ends;
        logic [N_VN-1:0] w5, w0;

        // Filler indices lie in 100..499; column 5 only in rows 0,10,20,30; column 0 in rows 1..3
        // next to padding slots 1023 and 600.
        for (int r = 0; r < N_CN; r++)
            for (int k = 0; k < ROW_DEG; k++)
                rom_mem[r][k*IDX_W +: IDX_W] = IDX_W'(100 + (r + k*50) % 400);
        for (int r = 0; r < 40; r += 10) rom_mem[r][0 +: IDX_W] = 10'd5;
        for (int r = 1; r < 4; r++) begin
            rom_mem[r][1*IDX_W +: IDX_W] = 10'd0;
            rom_mem[r][2*IDX_W +: IDX_W] = 10'h3FF;
            rom_mem[r][3*IDX_W +: IDX_W] = 10'd600;
        end
        w5 = '0; w5[5] = 1'b1;
        // Bit 67 = 600 mod N_VN: catches padding indices that alias into range.
        w0 = '0; w0[0] = 1'b1; w0[67] = 1'b1;

        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_ctrl", {rom_re, chk_busy, flag_chk_end, flag_iter_next, flag_dec_done, dec_success}, 6'b0);
        check_eq("rst_addr", rom_addr, 0);
        check_eq("rst_unsat", unsat_cnt, 0);
        check_eq("rst_iter", iter_cnt, 0);
        check_eq("rst_bits", dec_bits, 0);
        sys_rst = 1'b0;

        // All-zero word decodes immediately.
        pulse_start();
        bit_data_reg = '0;
        run_pass("zero", lat, itn, dd);
        check_eq("zero_lat", lat, 270);
        check_eq("zero_unsat", unsat_cnt, 0);
        check_eq("zero_flags", {itn, dd, dec_success}, 3'b011);
        check_eq("zero_iter", iter_cnt, 1);

        // Single error at bit 5: four unsatisfied checks until the iteration limit.
        pulse_start();
        bit_data_reg = w5;
        for (int p = 1; p <= MAX_ITER; p++) begin
            run_pass($sformatf("e5_p%0d", p), lat, itn, dd);
            check_eq($sformatf("e5_p%0d_iter", p), iter_cnt, p);
            if (p < MAX_ITER) check_eq($sformatf("e5_p%0d_next", p), {itn, dd}, 2'b10);
        end
        check_eq("e5_unsat", unsat_cnt, 4);
        check_eq("e5_final", {itn, dd, dec_success}, 3'b010);
        check_eq("e5_bits", dec_bits, w5);

        // Extra pass after done: iteration count saturates, fail reported again.
        run_pass("sat", lat, itn, dd);
        check_eq("sat_iter", iter_cnt, MAX_ITER);
        check_eq("sat_flags", {itn, dd, dec_success}, 3'b010);

        // Column 0 weight 3; padding must not contribute.
        pulse_start();
        bit_data_reg = w0;
        run_pass("pad", lat, itn, dd);
        check_eq("pad_unsat", unsat_cnt, 3);
        check_eq("pad_flags", {itn, dd}, 2'b10);
        check_eq("pad_iter", iter_cnt, 1);
        check_eq("pad_bits_held", dec_bits, w5);

        // Abort mid-RUN at row 100.
        bit_data_reg = w0 | w5;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b1;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b0;
        wait_row("abort", 100);
        flag_dec_start = 1'b1;
        @(posedge sys_clk) #1 flag_dec_start = 1'b0;
        check_eq("abort_idle", {rom_re, chk_busy}, 2'b00);
        check_eq("abort_iter", iter_cnt, 0);
        ends = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (flag_chk_end || flag_iter_next || flag_dec_done) ends++;
        end
        check_eq("abort_no_pulse", ends, 0);
        run_pass("after_abort", lat, itn, dd);
        check_eq("after_abort_lat", lat, 270);
        check_eq("after_abort_unsat", unsat_cnt, 7);
        check_eq("after_abort_iter", iter_cnt, 1);

        // Second VFU pulse during RUN is ignored.
        @(posedge sys_clk) #1 flag_VFU_end = 1'b1;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b0;
        wait_row("dup", 50);
        flag_VFU_end = 1'b1;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b0;
        ends = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            if (flag_chk_end) ends++;
        end
        check_eq("dup_one_end", ends, 1);
        check_eq("dup_iter", iter_cnt, 2);

        // Asynchronous reset mid-RUN clears everything before the next edge.
        @(posedge sys_clk) #1 flag_VFU_end = 1'b1;
        @(posedge sys_clk) #1 flag_VFU_end = 1'b0;
        wait_row("mrst", 20);
        sys_rst = 1'b1;
        #1;
        check_eq("mrst_ctrl", {rom_re, chk_busy, flag_chk_end, flag_iter_next, flag_dec_done, dec_success}, 6'b0);
        check_eq("mrst_addr", rom_addr, 0);
        check_eq("mrst_cnts", {unsat_cnt, iter_cnt}, 0);
        check_eq("mrst_bits", dec_bits, 0);
        @(posedge sys_clk) #1 sys_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
